// File: rtl/axi_master_ctrl.sv
// Single-outstanding AXI4 burst master: accepts one command, runs INCR address/data/response phases, reports completion.
// W path is combinational pass-through; read beats and completion flags are registered one cycle; user writes back-pressured by wready.
module axi_master_ctrl #(
    parameter int addr_width = 32,
    parameter int data_width = 32,
    parameter int id_width   = 4
) (
    input  logic                    clk,
    input  logic                    rst,
    // command
    input  logic                    cmd_valid,
    output logic                    cmd_ready,
    input  logic                    cmd_write,
    input  logic [addr_width-1:0]   cmd_addr,
    input  logic [7:0]              cmd_len,
    input  logic [id_width-1:0]     cmd_id,
    // user write data
    input  logic [data_width-1:0]   wd_data,
    input  logic                    wd_valid,
    output logic                    wd_ready,
    // user read data
    output logic [data_width-1:0]   rd_data,
    output logic                    rd_valid,
    output logic                    rd_last,
    // completion
    output logic                    done,
    output logic                    done_err,
    output logic [1:0]              done_resp,
    // AW
    output logic [id_width-1:0]     awid,
    output logic [addr_width-1:0]   awaddr,
    output logic [7:0]              awlen,
    output logic [2:0]              awsize,
    output logic [1:0]              awburst,
    output logic                    awvalid,
    input  logic                    awready,
    // W
    output logic [data_width-1:0]   wdata,
    output logic [data_width/8-1:0] wstrb,
    output logic                    wvalid,
    output logic                    wlast,
    input  logic                    wready,
    // B
    input  logic [id_width-1:0]     bid,
    input  logic [1:0]              bresp,
    input  logic                    bvalid,
    output logic                    bready,
    // AR
    output logic [id_width-1:0]     arid,
    output logic [addr_width-1:0]   araddr,
    output logic [7:0]              arlen,
    output logic [2:0]              arsize,
    output logic [1:0]              arburst,
    output logic                    arvalid,
    input  logic                    arready,
    // R
    input  logic [data_width-1:0]   rdata,
    input  logic [id_width-1:0]     rid,
    input  logic [1:0]              rresp,
    input  logic                    rvalid,
    input  logic                    rlast,
    output logic                    rready
);

    typedef enum logic [2:0] {IDLE, WR_ADDR, WR_DATA, WR_RESP, RD_ADDR, RD_DATA} state_t;

    localparam logic [2:0] size_c  = 3'($clog2(data_width / 8));
    localparam logic [1:0] burst_c = 2'b01;

    state_t                state;
    logic [addr_width-1:0] addr_q;
    logic [7:0]            len_q;
    logic [7:0]            cnt;
    logic [id_width-1:0]   id_q;
    logic                  started;
    logic                  err_acc;
    logic [1:0]            resp_acc;
    logic                  last_beat;
    logic                  rbeat_err;

    assign last_beat = (cnt == len_q);
    assign rbeat_err = (rresp != 2'b00) || (rid != id_q) || (rlast != last_beat);

    // started keeps cmd_ready low until the first edge after reset release
    assign cmd_ready = started && (state == IDLE) && !done;

    assign awid    = id_q;
    assign awaddr  = addr_q;
    assign awlen   = len_q;
    assign awsize  = size_c;
    assign awburst = burst_c;
    assign awvalid = (state == WR_ADDR);

    assign wdata    = wd_data;
    assign wstrb    = '1;
    assign wvalid   = (state == WR_DATA) && wd_valid;
    assign wd_ready = (state == WR_DATA) && wready;
    assign wlast    = (state == WR_DATA) && last_beat;

    assign bready = (state == WR_RESP);

    assign arid    = id_q;
    assign araddr  = addr_q;
    assign arlen   = len_q;
    assign arsize  = size_c;
    assign arburst = burst_c;
    assign arvalid = (state == RD_ADDR);

    assign rready = (state == RD_DATA);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= IDLE;
            addr_q    <= '0;
            len_q     <= '0;
            cnt       <= '0;
            id_q      <= '0;
            started   <= 1'b0;
            err_acc   <= 1'b0;
            resp_acc  <= 2'b00;
            rd_data   <= '0;
            rd_valid  <= 1'b0;
            rd_last   <= 1'b0;
            done      <= 1'b0;
            done_err  <= 1'b0;
            done_resp <= 2'b00;
        end else begin
            started  <= 1'b1;
            rd_valid <= 1'b0;
            rd_last  <= 1'b0;
            done     <= 1'b0;
            case (state)
                IDLE: begin
                    if (cmd_valid && cmd_ready) begin
                        addr_q   <= cmd_addr;
                        len_q    <= cmd_len;
                        id_q     <= cmd_id;
                        cnt      <= '0;
                        err_acc  <= 1'b0;
                        resp_acc <= 2'b00;
                        state    <= cmd_write ? WR_ADDR : RD_ADDR;
                    end
                end
                WR_ADDR: if (awready) state <= WR_DATA;
                WR_DATA: begin
                    if (wvalid && wready) begin
                        if (last_beat) state <= WR_RESP;
                        else           cnt   <= cnt + 8'd1;
                    end
                end
                WR_RESP: begin
                    if (bvalid) begin
                        done      <= 1'b1;
                        done_resp <= bresp;
                        done_err  <= (bresp != 2'b00) || (bid != id_q);
                        state     <= IDLE;
                    end
                end
                RD_ADDR: if (arready) state <= RD_DATA;
                RD_DATA: begin
                    if (rvalid) begin
                        rd_valid <= 1'b1;
                        rd_data  <= rdata;
                        rd_last  <= last_beat;
                        if (resp_acc == 2'b00) resp_acc <= rresp;
                        // an early rlast also terminates the burst, flagged as an error
                        if (last_beat || rlast) begin
                            done      <= 1'b1;
                            done_err  <= err_acc || rbeat_err;
                            done_resp <= (resp_acc != 2'b00) ? resp_acc : rresp;
                            state     <= IDLE;
                        end else begin
                            err_acc <= err_acc || rbeat_err;
                            cnt     <= cnt + 8'd1;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
